// File: rtl/dec_digit_to_bin_pkg.sv
// ---------------------------------------------------------------------------
// dec_digit_to_bin_pkg
// Shared definitions for the decimal-digit-to-binary accumulator:
//   - state_e   : 2-bit FSM encoding (IDLE=0, MUL=1, ADD=2, DONE=3)
//   - DEC_BASE  : radix of the entered number
//   - BCD_MAX   : largest legal BCD digit
//   - is_bcd()  : legality check for an incoming digit
// ---------------------------------------------------------------------------
package dec_digit_to_bin_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ADD  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int         DEC_BASE = 10;
    localparam logic [3:0] BCD_MAX  = 4'd9;

    // Codes 10..15 are not decimal digits and must be rejected.
    function automatic logic is_bcd(input logic [3:0] d);
        return (d <= BCD_MAX);
    endfunction

endpackage : dec_digit_to_bin_pkg

// File: rtl/dec_digit_to_bin_if.sv
// ---------------------------------------------------------------------------
// dec_digit_to_bin_if
// Digit-entry / result bus of the accumulator.
//   master : digit source and result consumer (drives clear, digit_valid,
//            digit, enter; observes everything else)
//   slave  : the accumulator (drives digit_ready, value_valid, value_out,
//            overflow, digit_err, digit_count)
// ---------------------------------------------------------------------------
interface dec_digit_to_bin_if #(
    parameter int WIDTH      = 6,
    parameter int MAX_DIGITS = 2
);
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    logic             clear;
    logic             digit_valid;
    logic [3:0]       digit;
    logic             digit_ready;
    logic             enter;
    logic             value_valid;
    logic [WIDTH-1:0] value_out;
    logic             overflow;
    logic             digit_err;
    logic [CNT_W-1:0] digit_count;

    modport master (
        output clear, digit_valid, digit, enter,
        input  digit_ready, value_valid, value_out, overflow, digit_err, digit_count
    );

    modport slave (
        input  clear, digit_valid, digit, enter,
        output digit_ready, value_valid, value_out, overflow, digit_err, digit_count
    );

endinterface : dec_digit_to_bin_if

// File: rtl/dec_digit_to_bin_times_ten.sv
// ---------------------------------------------------------------------------
// dec_digit_to_bin_times_ten
// Combinational multiply-by-ten as (x<<3)+(x<<1), widened by four bits so
// that 10*(2^WIDTH-1) never wraps.
//   x_i : WIDTH-bit unsigned operand
//   y_o : WIDTH+4-bit product
// ---------------------------------------------------------------------------
module dec_digit_to_bin_times_ten #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] x_i,
    output logic [WIDTH+3:0] y_o
);
    logic [WIDTH+3:0] x_ext_s;

    assign x_ext_s = {4'b0000, x_i};
    assign y_o     = (x_ext_s << 3) + (x_ext_s << 1);

endmodule : dec_digit_to_bin_times_ten

// File: rtl/dec_digit_to_bin.sv
// ---------------------------------------------------------------------------
// dec_digit_to_bin
// Sequential decimal-to-binary accumulator: value = value*10 + digit, one
// BCD digit per handshake. The multiply and the add take separate registered
// cycles (MUL, ADD). enter emits the accumulated value with a one-cycle
// value_valid pulse (DONE) and restarts the entry. Results above 2^WIDTH-1
// saturate to all ones and set a sticky overflow flag for the entry.
//   clk, rst : clock, synchronous active-high reset
//   bus_if   : slave side of dec_digit_to_bin_if (digit handshake, enter,
//              clear, result and status outputs)
// ---------------------------------------------------------------------------
module dec_digit_to_bin
    import dec_digit_to_bin_pkg::*;
#(
    parameter int WIDTH      = 6,
    parameter int MAX_DIGITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    dec_digit_to_bin_if.slave   bus_if
);
    localparam int               CNT_W   = $clog2(MAX_DIGITS + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [WIDTH+3:0] MAX_VAL = {4'b0000, {WIDTH{1'b1}}};

    state_e           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [3:0]       digit_q;
    logic [WIDTH+3:0] prod_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] value_q;
    logic             overflow_q;
    logic             valid_q;
    logic             err_q;

    logic [WIDTH+3:0] prod_d;
    logic [WIDTH+3:0] sum_s;
    logic             sat_s;
    logic [WIDTH-1:0] acc_d;
    logic             digit_ok_s;

    dec_digit_to_bin_times_ten #(.WIDTH(WIDTH)) u_times_ten (
        .x_i (acc_q),
        .y_o (prod_d)
    );

    // ADD stage: product plus latched digit, saturated to WIDTH bits.
    always_comb begin
        sum_s = prod_q + {{WIDTH{1'b0}}, digit_q};
        sat_s = (sum_s > MAX_VAL);
        if (sat_s) begin
            acc_d = {WIDTH{1'b1}};
        end else begin
            acc_d = sum_s[WIDTH-1:0];
        end
    end

    assign digit_ok_s = is_bcd(bus_if.digit) && (count_q < MAX_CNT);

    // Control FSM with all registered outputs; value_valid/digit_err default low so they pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            acc_q      <= {WIDTH{1'b0}};
            digit_q    <= 4'd0;
            prod_q     <= {(WIDTH+4){1'b0}};
            count_q    <= {CNT_W{1'b0}};
            value_q    <= {WIDTH{1'b0}};
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus_if.clear) begin
                        acc_q      <= {WIDTH{1'b0}};
                        count_q    <= {CNT_W{1'b0}};
                        overflow_q <= 1'b0;
                    end else if (bus_if.enter) begin
                        // Result is registered here so it is on the bus during DONE.
                        value_q <= acc_q;
                        valid_q <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (bus_if.digit_valid) begin
                        if (digit_ok_s) begin
                            digit_q <= bus_if.digit;
                            state_q <= ST_MUL;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    prod_q  <= prod_d;
                    state_q <= ST_ADD;
                end
                ST_ADD: begin
                    acc_q   <= acc_d;
                    count_q <= count_q + CNT_ONE;
                    if (sat_s) begin
                        overflow_q <= 1'b1;
                    end
                    state_q <= ST_IDLE;
                end
                ST_DONE: begin
                    acc_q      <= {WIDTH{1'b0}};
                    count_q    <= {CNT_W{1'b0}};
                    overflow_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus_if.digit_ready = (state_q == ST_IDLE) & ~bus_if.enter & ~bus_if.clear;
    assign bus_if.value_valid = valid_q;
    assign bus_if.value_out   = value_q;
    assign bus_if.overflow    = overflow_q;
    assign bus_if.digit_err   = err_q;
    assign bus_if.digit_count = count_q;

endmodule : dec_digit_to_bin

// File: doc/dec_digit_to_bin.md
Name: dec_digit_to_bin

Overview:
- Sequential decimal-to-binary accumulator: value = value*10 + digit, one decimal digit per handshake.
- Inverse of the binary-to-decimal path, which peels digits off by repeated subtract-10.
- Sits between keypad/switch digit entry and game-compare logic; emits the entered guess as a WIDTH-bit unsigned binary number.
- The multiply-by-10 and the add run in separate registered cycles.

Parameters:
WIDTH, 6, bit width of binary result; max representable value 2^WIDTH-1.
MAX_DIGITS, 2, max decimal digits accepted per entry.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
clear  in  1  abandon entry; zero accumulator, count, overflow
digit_valid  in  1  digit present
digit  in  4  BCD digit
digit_ready  out  1  digit accepted when digit_valid & digit_ready
enter  in  1  finish entry, emit result
value_valid  out  1  one-cycle pulse, result on value_out
value_out  out  WIDTH  converted binary value, held until next value_valid
overflow  out  1  sticky; entry exceeded 2^WIDTH-1 (saturated)
digit_err  out  1  one-cycle pulse; digit rejected
digit_count  out  clog2(MAX_DIGITS+1)  digits accepted this entry

Behaviour:
- Reset (rst=1 at posedge): state IDLE; acc=0; digit_count=0; value_out=0; overflow=0; value_valid=0; digit_err=0.
- Reset has priority over all inputs in every state, including mid-MUL/ADD; the in-flight digit is lost.
- FSM states: IDLE, MUL, ADD, DONE.
- digit_ready = (state==IDLE) & ~enter & ~clear. Combinational from state and inputs.
- Priority in IDLE: clear > enter > digit.
- IDLE, clear=1: acc, digit_count, overflow -> 0; stay IDLE; value_out unchanged.
- IDLE, enter=1: go DONE.
- IDLE, digit handshake, digit<=9, digit_count<MAX_DIGITS: latch digit; go MUL.
- IDLE, digit handshake, digit>9 or digit_count==MAX_DIGITS: digit_err=1 next cycle; acc unchanged; stay IDLE.
- MUL: prod = acc*10 computed as (acc<<3)+(acc<<1), WIDTH+4 bits wide; registered; go ADD.
- ADD: sum = prod + digit, WIDTH+4 bits.
  - sum > 2^WIDTH-1: acc = all ones; overflow=1.
  - otherwise acc = sum[WIDTH-1:0].
  - digit_count increments; go IDLE.
- DONE: value_out=acc; value_valid=1 for exactly this cycle; acc, digit_count, overflow cleared at end of cycle; go IDLE.
- Overflow is visible during the DONE cycle and cleared after it.
- clear and enter are ignored in MUL/ADD/DONE (digit_ready=0 there); the source must hold them.
- Timing:
  - digit accepted at edge N; acc updated at edge N+2; digit_ready high again in cycle N+2.
  - enter sampled at edge N; value_valid high in cycle N+1.
- enter with digit_count=0 emits value_out=0, valid pulse as normal.
- All outputs except digit_ready are registered.

Decomposition:
- Shared package: FSM state encoding (2-bit: IDLE=0, MUL=1, ADD=2, DONE=3), DEC_BASE=10, BCD_MAX=9.
- One sub-module is natural: times_ten, a combinational (x<<3)+(x<<1) with WIDTH in and WIDTH+4 out, instanced in the MUL stage.

Test Plan:
- Digits 4 then 2, then enter -> acc=4 after first, 42 after second; value_valid one cycle with value_out=42; overflow=0; digit_count back to 0.
- Digits 9,9 then enter -> after second digit acc=63, overflow=1; value_out=63 with overflow=1 in DONE cycle; overflow=0 afterward.
- digit=12 in IDLE -> digit_err pulse one cycle; acc and digit_count unchanged. Then digit 7 + enter -> 7.
- Digits 1,2,3 with MAX_DIGITS=2 -> third rejected with digit_err; enter yields 12.
- digit_valid and enter same cycle, acc=5 -> digit_ready=0; value_out=5; digit not consumed.
- Assert rst during the MUL cycle of digit 3 (acc=6) -> all outputs and acc=0 next cycle; a following enter yields 0.
